// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues word-aligned imem requests,
// buffers returned instructions with their PC and hands them to decode.
module fetch_unit #(
    parameter int               Width   = 32,
    parameter logic [Width-1:0] ResetPc = '0,
    parameter int               Depth   = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_valid,
    input  logic             imem_ready,
    output logic [Width-1:0] imem_addr,
    input  logic [Width-1:0] imem_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [Width-1:0] inst_data,
    output logic [Width-1:0] inst_pc,
    input  logic             redirect_valid,
    input  logic [Width-1:0] redirect_pc,
    input  logic             halt
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [Width-1:0] AlignMask = ~Width'(3);

    logic [Width-1:0] fetch_pc;
    logic [Width-1:0] inflight_pc;
    logic [Width-1:0] buf_pc    [Depth];
    logic [Width-1:0] buf_instr [Depth];
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;
    logic [CntW-1:0]  count;
    logic             inflight;
    logic             kill;

    logic             accept;
    logic             pop;
    logic             push;
    logic [CntW:0]    occupancy;
    logic [Width-1:0] redirect_target;

    // Entries that will be held once the in-flight response lands.
    assign pop       = inst_valid && inst_ready;
    assign occupancy = {1'b0, count}
                     + {{CntW{1'b0}}, inflight}
                     - {{CntW{1'b0}}, pop};

    assign imem_valid = !reset && !halt && !redirect_valid
                     && (occupancy < (CntW + 1)'(Depth));
    assign imem_addr  = fetch_pc;
    assign accept     = imem_valid && imem_ready;

    // A redirect flushes the buffer, so the response landing now is dropped.
    assign push = inflight && !kill && !redirect_valid;

    assign redirect_target = redirect_pc & AlignMask;

    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? buf_instr[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? buf_pc[rd_ptr] : '0;

    // Control state: PC, request tracking, buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= ResetPc & AlignMask;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            kill        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            kill     <= inflight || accept;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (accept) begin
                fetch_pc    <= fetch_pc + Width'(4);
                inflight_pc <= fetch_pc;
            end
            inflight <= accept;
            kill     <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            if (push && !pop) begin
                count <= count + CntW'(1);
            end else if (pop && !push) begin
                count <= count - CntW'(1);
            end
        end
    end

    // Buffer storage: capture the returned word with the PC it came from.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            buf_pc[wr_ptr]    <= inflight_pc;
            buf_instr[wr_ptr] <= imem_data;
        end
    end

    // The request throttle must keep a push from ever overfilling the buffer.
    overflow_check: assert property (
        @(posedge clk) disable iff (reset)
        !(push && !pop && count == CntW'(Depth))
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand-written halt,
// stall and mid-run reset sequences for fetch_unit.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_valid;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .Width  (32),
        .ResetPc(32'h0),
        .Depth  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_valid    (imem_valid),
        .imem_ready    (imem_ready),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word k holds k, data appears the cycle after accept.
    always @(posedge clk) begin
        if (imem_valid && imem_ready)
            imem_data <= imem_addr >> 2;
        else
            imem_data <= 32'hdead_beef;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ir;
        logic        dr;
        logic        rv;
        logic [31:0] rpc;
        logic        h;
        logic        e_iv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic ir, input logic dr,
        input logic rv, input logic [31:0] rpc, input logic h,
        input logic e_iv, input logic [31:0] e_addr,
        input logic e_ov, input logic [31:0] e_pc,
        input logic [31:0] e_data);
        vec_t v;
        v.rst = rst; v.ir = ir; v.dr = dr; v.rv = rv;
        v.rpc = rpc; v.h = h;
        v.e_iv = e_iv; v.e_addr = e_addr; v.e_ov = e_ov;
        v.e_pc = e_pc; v.e_data = e_data;
        return v;
    endfunction

    vec_t vecs [19];

    initial begin
        logic [31:0] exp_pc;
        logic        stalled;
        logic [31:0] st_addr;
        logic        acc_prev;
        logic        did_reset;
        logic        after_rst;
        int          pops;
        logic        h_ov [8];
        logic [31:0] h_pc [8];
        logic        h_iv [8];
        logic [31:0] h_addr [8];

        // rst ir dr rv rpc h | iv addr ov pc data
        vecs[0]  = mk(1,1,1,0,0,0, 0,32'h00,  0,32'h0,  32'h0);
        vecs[1]  = mk(0,1,1,0,0,0, 1,32'h00,  0,32'h0,  32'h0);
        vecs[2]  = mk(0,1,1,0,0,0, 1,32'h04,  0,32'h0,  32'h0);
        vecs[3]  = mk(0,1,1,0,0,0, 1,32'h08,  1,32'h0,  32'h0);
        vecs[4]  = mk(0,1,1,0,0,0, 1,32'h0c,  1,32'h4,  32'h1);
        vecs[5]  = mk(0,1,0,0,0,0, 0,32'h10,  1,32'h8,  32'h2);
        vecs[6]  = mk(0,1,0,0,0,0, 0,32'h10,  1,32'h8,  32'h2);
        vecs[7]  = mk(0,1,0,0,0,0, 0,32'h10,  1,32'h8,  32'h2);
        vecs[8]  = mk(0,1,1,0,0,0, 1,32'h10,  1,32'h8,  32'h2);
        vecs[9]  = mk(0,1,1,0,0,0, 1,32'h14,  1,32'hc,  32'h3);
        vecs[10] = mk(0,0,1,0,0,0, 1,32'h18,  1,32'h10, 32'h4);
        vecs[11] = mk(0,0,1,0,0,0, 1,32'h18,  1,32'h14, 32'h5);
        vecs[12] = mk(0,1,1,0,0,0, 1,32'h18,  0,32'h0,  32'h0);
        vecs[13] = mk(0,1,1,0,0,0, 1,32'h1c,  0,32'h0,  32'h0);
        vecs[14] = mk(0,1,1,1,32'h103,0, 0,32'h20, 1,32'h18, 32'h6);
        vecs[15] = mk(0,1,1,0,0,0, 1,32'h100, 0,32'h0,  32'h0);
        vecs[16] = mk(0,1,1,0,0,0, 1,32'h104, 0,32'h0,  32'h0);
        vecs[17] = mk(0,1,1,0,0,0, 1,32'h108, 1,32'h100,32'h40);
        vecs[18] = mk(0,1,1,0,0,0, 1,32'h10c, 1,32'h104,32'h41);

        reset = 1; imem_ready = 0; inst_ready = 0;
        redirect_valid = 0; redirect_pc = 0; halt = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            reset          = vecs[i].rst;
            imem_ready     = vecs[i].ir;
            inst_ready     = vecs[i].dr;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            halt           = vecs[i].h;
            @(negedge clk);
            chk($sformatf("vec%0d_imem_valid", i),
                {31'b0, imem_valid}, {31'b0, vecs[i].e_iv});
            chk($sformatf("vec%0d_imem_addr", i),
                imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_inst_valid", i),
                {31'b0, inst_valid}, {31'b0, vecs[i].e_ov});
            chk($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_inst_data", i),
                inst_data, vecs[i].e_data);
            @(posedge clk); #1;
        end

        // Halt for 5 cycles: in-flight word lands, buffer drains,
        // then fetch resumes at the next sequential PC.
        h_iv   = '{0, 0, 0, 0, 0, 1, 1, 1};
        h_addr = '{32'h110, 32'h110, 32'h110, 32'h110, 32'h110,
                   32'h110, 32'h114, 32'h118};
        h_ov   = '{1, 1, 0, 0, 0, 0, 0, 1};
        h_pc   = '{32'h108, 32'h10c, 0, 0, 0, 0, 0, 32'h110};
        for (int i = 0; i < 8; i++) begin
            reset = 0; imem_ready = 1; inst_ready = 1;
            redirect_valid = 0;
            halt = (i < 5);
            @(negedge clk);
            chk($sformatf("halt%0d_imem_valid", i),
                {31'b0, imem_valid}, {31'b0, h_iv[i]});
            if (h_iv[i])
                chk($sformatf("halt%0d_imem_addr", i),
                    imem_addr, h_addr[i]);
            chk($sformatf("halt%0d_inst_valid", i),
                {31'b0, inst_valid}, {31'b0, h_ov[i]});
            chk($sformatf("halt%0d_inst_pc", i), inst_pc, h_pc[i]);
            if (h_ov[i])
                chk($sformatf("halt%0d_inst_data", i),
                    inst_data, h_pc[i] >> 2);
            @(posedge clk); #1;
        end
        halt = 0;

        // Random imem_ready/inst_ready with a reset landing on a
        // cycle whose response is still in flight.
        exp_pc = 0; stalled = 0; st_addr = 0; acc_prev = 0;
        did_reset = 0; after_rst = 0; pops = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            reset = (cyc == 0)
                 || (!did_reset && cyc >= 40 && (acc_prev || cyc >= 70));
            if (reset && cyc != 0) did_reset = 1;
            imem_ready = ($urandom_range(0, 2) != 0);
            inst_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (reset) begin
                chk("rst_imem_valid", {31'b0, imem_valid}, 32'h0);
                exp_pc = 0; stalled = 0; acc_prev = 0;
                after_rst = 1;
            end else begin
                if (after_rst) begin
                    chk("post_reset_addr", imem_addr, 32'h0);
                    chk("post_reset_inst_valid",
                        {31'b0, inst_valid}, 32'h0);
                    after_rst = 0;
                end
                if (stalled) begin
                    chk("stall_valid", {31'b0, imem_valid}, 32'h1);
                    chk("stall_addr", imem_addr, st_addr);
                end
                if (inst_valid && inst_ready) begin
                    chk("rand_inst_pc", inst_pc, exp_pc);
                    chk("rand_inst_data", inst_data, exp_pc >> 2);
                    exp_pc = exp_pc + 4;
                    pops++;
                end
                stalled  = imem_valid && !imem_ready;
                st_addr  = imem_addr;
                acc_prev = imem_valid && imem_ready;
            end
            @(posedge clk); #1;
        end
        chk("mid_reset_taken", {31'b0, did_reset}, 32'h1);
        checks++;
        if (pops < 20) begin
            errors++;
            $display("FAIL rand_progress: got %0d pops expected >= 20",
                     pops);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the decoder. It owns the program counter and issues word-aligned read requests to the synchronous instruction memory. Returned instructions are buffered with their PC in a small FIFO and handed to decode over a valid/ready handshake. It also handles control-flow redirects (branch/jal) and WFI halt by flushing and re-steering the fetch stream.

## Interface
- Width, 32: address/instruction width in bits.
- ResetPc, 'h0: PC of the first fetch after reset; bits [1:0] must be 0.
- Depth, 2: instruction buffer entries (≥2, power of two).

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- imem_valid  out  1  fetch request valid.
- imem_ready  in  1  memory accepts request this cycle.
- imem_addr  out  Width  request address, always [1:0]=0.
- imem_data  in  Width  read data, valid exactly 1 cycle after an accepted request.
- inst_valid  out  1  head of buffer valid to decoder.
- inst_ready  in  1  decoder consumes head this cycle.
- inst_data  out  Width  instruction at buffer head.
- inst_pc  out  Width  PC of inst_data.
- redirect_valid  in  1  control-flow redirect (taken branch/jal).
- redirect_pc  in  Width  redirect target; bits [1:0] ignored, forced 0.
- halt  in  1  stop issuing new fetches (WFI); level-sensitive.

## Operation
- State: fetch_pc, FIFO of Depth entries {pc, instr}, count (0..Depth), inflight flag with inflight_pc, kill flag.
- Accept = imem_valid && imem_ready; pop = inst_valid && inst_ready.
- imem_valid = !reset && !halt && !redirect_valid && (count + inflight − pop) < Depth.
- imem_addr = fetch_pc. On accept: fetch_pc += 4 (mod 2^Width, wraps silently), inflight=1, inflight_pc=fetch_pc.
- Response: cycle after accept, if kill=0, push {inflight_pc, imem_data} into FIFO; if kill=1, discard. inflight clears unless a new accept occurs same cycle.
- Push and pop in same cycle: count unchanged; push with count==Depth cannot occur by construction (checker asserts).
- inst_valid = (count != 0); inst_data/inst_pc = head entry; 0 when empty.
- Redirect (priority over everything except reset): pop in the same cycle still completes (decoder already holds that instruction); all remaining FIFO entries flushed (count=0); fetch_pc=redirect_pc&~3; kill=1 if inflight or accept this cycle (accept is impossible since imem_valid is low); no request issued in redirect cycle.
- kill clears when the killed response cycle passes.
- halt: no new requests; in-flight response still lands; FIFO drains normally; redirect during halt updates fetch_pc and flushes. Deassert → requests resume next cycle from fetch_pc.
- Reset mid-operation: all state cleared on that edge; any response from a pre-reset request is discarded (kill semantics via inflight clear).

## Timing
- Reset values: imem_valid=0 (while reset high), imem_addr=ResetPc, inst_valid=0, inst_data=0, inst_pc=0, count=0, inflight=0, kill=0.
- Fetch latency: request accepted cycle N → instruction in FIFO at end of N+1 → inst_valid high in N+2 (no bypass).
- Steady state with inst_ready=1, imem_ready=1: one instruction per cycle after initial 2-cycle latency.
- Redirect at cycle R: request for target issued R+1, target instruction valid at R+3.
- imem_ready low: imem_addr/imem_valid held stable until accepted (unless redirect/halt drops request).

## Test plan
- Reset release, imem_ready=1, inst_ready=1, memory word k = k: requests at 0,4,8…; inst_valid rises 2 cycles after reset low; inst_pc 0,4,8 back-to-back with inst_data 0,1,2.
- inst_ready=0 for 6 cycles: exactly Depth entries buffered, imem_valid drops, no request beyond PC 4 (Depth=2); releasing ready delivers 0,4,8 in order without gaps/duplicates.
- Redirect to 'h100 while FIFO full and a request in flight, pop in same cycle: popped instr delivered once, next inst_pc='h100 at R+3, killed response never appears.
- redirect_pc='h103: fetch resumes at 'h100.
- halt high 5 cycles mid-stream: in-flight instr lands, FIFO drains, no imem_valid; after deassert requests resume at next sequential PC.
- imem_ready toggling randomly plus reset asserted mid-run with request in flight: addresses stable while stalled; after reset first inst_pc=ResetPc, no stale data.
